// File: rtl/apv_ped_zs_stage.sv
// APV frame pedestal subtraction and zero suppression stage.
// Pops a show-ahead FIFO and emits tagged header, sample and trailer words through a register slice.
module apv_ped_zs_stage #(
    parameter int unsigned N_CH = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [12:0] fifo_data_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_o,
    input  logic        zs_en_i,
    input  logic [11:0] threshold_i,
    input  logic        ped_we_i,
    input  logic [6:0]  ped_addr_i,
    input  logic [11:0] ped_data_i,
    output logic [21:0] out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] frame_cnt_o,
    output logic        busy_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHdr  = 2'd1;
    localparam logic [1:0] StSamp = 2'd2;
    localparam logic [1:0] StTrl  = 2'd3;
    localparam logic [6:0] LastCh = 7'(N_CH - 1);

    logic [1:0]  state_q, state_d;
    logic [6:0]  ch_q, ch_d;
    logic [7:0]  kept_q, kept_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [21:0] out_data_q, out_data_d;
    logic [11:0] ped_q [128];

    logic [11:0] word;
    logic [11:0] ped_rd;
    logic [12:0] diff;
    logic [11:0] value;
    logic        keep;
    logic        drop;
    logic        pop;
    logic        emit;
    logic        unused_word_msb;

    assign unused_word_msb = fifo_data_i[12];
    assign word   = fifo_data_i[11:0];
    assign ped_rd = ped_q[ch_q];

    always_comb begin
        diff  = {1'b0, word} - {1'b0, ped_rd};
        value = diff[12] ? 12'd0 : diff[11:0];
        keep  = ~zs_en_i | (value > threshold_i);
        drop  = (state_q == StSamp) & ~keep;
        // Dropped samples never touch the output slot, so they may pop under backpressure.
        pop   = ~fifo_empty_i & (state_q != StIdle) & (~out_valid_q | out_ready_i | drop);
        emit  = pop & ~drop;
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        kept_d      = kept_q;
        frame_cnt_d = frame_cnt_q;
        out_valid_d = out_valid_q & ~out_ready_i;
        out_data_d  = out_data_q;
        unique case (state_q)
            StIdle: begin
                if (enable_i) state_d = StHdr;
            end
            StHdr: begin
                if (pop) begin
                    out_data_d = {2'b01, 8'd0, word};
                    ch_d       = 7'd0;
                    state_d    = StSamp;
                end
            end
            StSamp: begin
                if (pop) begin
                    if (keep) begin
                        out_data_d = {2'b10, 1'b0, ch_q, value};
                        kept_d     = kept_q + 8'd1;
                    end
                    if (ch_q == LastCh) state_d = StTrl;
                    else                ch_d    = ch_q + 7'd1;
                end
            end
            StTrl: begin
                if (pop) begin
                    out_data_d  = {2'b11, kept_q, word};
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    kept_d      = 8'd0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (emit) out_valid_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ch_q        <= 7'd0;
            kept_q      <= 8'd0;
            frame_cnt_q <= 16'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 22'd0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            kept_q      <= kept_d;
            frame_cnt_q <= frame_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 128; i++) ped_q[i] <= 12'd0;
        end else if (ped_we_i) begin
            ped_q[ped_addr_i] <= ped_data_i;
        end
    end

    assign fifo_rd_o   = pop;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign frame_cnt_o = frame_cnt_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_apv_ped_zs_stage.sv
// Directed bench for apv_ped_zs_stage: a show-ahead FIFO model feeds frames and a
// monitor collects handshaked output words for comparison against expected words.
module tb_apv_ped_zs_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        zs_en = 1'b0;
    logic [11:0] threshold = 12'd0;
    logic        ped_we = 1'b0;
    logic [6:0]  ped_addr = 7'd0;
    logic [11:0] ped_data = 12'd0;
    logic        out_ready = 1'b1;
    logic        ready_mode = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic [12:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [21:0] out_data;
    logic        out_valid;
    logic [15:0] frame_cnt;
    logic        busy;

    logic [12:0] mem [1024];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    logic [11:0] ped_m [128];
    logic [12:0] smp [128];
    logic [21:0] exp_q [$];
    logic [21:0] got_q [$];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    apv_ped_zs_stage #(.N_CH(128)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .enable_i    (enable),
        .fifo_data_i (fifo_data),
        .fifo_empty_i(fifo_empty),
        .fifo_rd_o   (fifo_rd),
        .zs_en_i     (zs_en),
        .threshold_i (threshold),
        .ped_we_i    (ped_we),
        .ped_addr_i  (ped_addr),
        .ped_data_i  (ped_data),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .frame_cnt_o (frame_cnt),
        .busy_o      (busy)
    );

    assign fifo_data  = mem[rd_ptr[9:0]];
    assign fifo_empty = (rd_ptr == wr_ptr) | stall;

    always @(posedge clk) begin
        if (flush)        rd_ptr <= wr_ptr;
        else if (fifo_rd) rd_ptr <= rd_ptr + 1;
        out_ready <= ready_mode ? ~out_ready : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Output monitor; also checks that a stalled word is held unchanged.
    logic        pv = 1'b0;
    logic        pr = 1'b1;
    logic [21:0] pd = 22'd0;
    always @(negedge clk) begin
        if (pv && !pr && !rst) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {10'd0, out_data}, {10'd0, pd});
        end
        if (out_valid && out_ready) got_q.push_back(out_data);
        pv = out_valid;
        pr = out_ready;
        pd = out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [12:0] w);
        mem[wr_ptr[9:0]] = w;
        wr_ptr++;
    endtask

    task automatic ped_write(input logic [6:0] a, input logic [11:0] d);
        ped_addr = a;
        ped_data = d;
        ped_we   = 1'b1;
        tick();
        ped_we   = 1'b0;
        ped_m[a] = d;
    endtask

    // Queue a frame into the FIFO model and build its expected output words.
    task automatic build(input logic [12:0] hdr, input logic [12:0] trl);
        logic [11:0] v;
        logic [7:0]  kept;
        kept = 8'd0;
        exp_q.delete();
        got_q.delete();
        push(hdr);
        exp_q.push_back({2'b01, 8'd0, hdr[11:0]});
        for (int c = 0; c < 128; c++) begin
            push(smp[c]);
            v = (smp[c][11:0] > ped_m[c]) ? smp[c][11:0] - ped_m[c] : 12'd0;
            if (!zs_en || v > threshold) begin
                exp_q.push_back({2'b10, 1'b0, 7'(c), v});
                kept++;
            end
        end
        push(trl);
        exp_q.push_back({2'b11, kept, trl[11:0]});
    endtask

    task automatic start();
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic finish_frame(input string name);
        for (int c = 0; c < 1000 && got_q.size() < exp_q.size(); c++) tick();
        repeat (4) tick();
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check($sformatf("%s[%0d]", name, i), {10'd0, got_q[i]}, {10'd0, exp_q[i]});
        end
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [21:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 22'h3FFFFF;
    endfunction

    initial begin
        int base;
        int n;
        int trl_cnt;
        for (int c = 0; c < 128; c++) ped_m[c] = 12'd0;

        // Reset state
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {10'd0, out_data}, 32'd0);
        check("rst_rd", {31'd0, fifo_rd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // Plain forwarding, bit 12 set on header must be ignored
        for (int c = 0; c < 128; c++) smp[c] = 13'(c);
        build(13'h1E55, 13'h0105);
        start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        finish_frame("t1");
        check("t1_hdr", {10'd0, got_at(0)}, 32'h100E55);
        check("t1_ch0", {10'd0, got_at(1)}, 32'h200000);
        check("t1_ch5", {10'd0, got_at(6)}, 32'h205005);
        check("t1_ch127", {10'd0, got_at(128)}, 32'h27F07F);
        check("t1_trl", {10'd0, got_at(129)}, 32'h380105);
        check("t1_fcnt", {16'd0, frame_cnt}, 32'd1);

        // Pedestal subtraction with clamp
        ped_write(7'd5, 12'd100);
        ped_write(7'd6, 12'd100);
        smp[5] = 13'd60;
        smp[6] = 13'd350;
        build(13'h0123, 13'h0456);
        start();
        finish_frame("t2");
        check("t2_ch5", {10'd0, got_at(6)}, 32'h205000);
        check("t2_ch6", {10'd0, got_at(7)}, 32'h2060FA);
        check("t2_fcnt", {16'd0, frame_cnt}, 32'd2);

        // Zero suppression, strict threshold
        zs_en = 1'b1;
        threshold = 12'd200;
        for (int c = 0; c < 128; c++) smp[c] = 13'd0;
        smp[10] = 13'd201;
        smp[20] = 13'd200;
        smp[30] = 13'h1FFF;
        build(13'h0ABC, 13'h00AB);
        start();
        finish_frame("t3");
        check("t3_n", got_q.size(), 32'd4);
        check("t3_hdr", {10'd0, got_at(0)}, 32'h100ABC);
        check("t3_s201", {10'd0, got_at(1)}, 32'h20A0C9);
        check("t3_s4095", {10'd0, got_at(2)}, 32'h21EFFF);
        check("t3_trl", {10'd0, got_at(3)}, 32'h3020AB);
        check("t3_fcnt", {16'd0, frame_cnt}, 32'd3);

        // Toggling backpressure
        zs_en = 1'b0;
        ready_mode = 1'b1;
        for (int c = 0; c < 128; c++) smp[c] = 13'(4095 - c);
        build(13'h0777, 13'h0888);
        start();
        finish_frame("t4");
        check("t4_fcnt", {16'd0, frame_cnt}, 32'd4);
        ready_mode = 1'b0;
        tick();
        tick();

        // FIFO empty gap after ch63
        for (int c = 0; c < 128; c++) smp[c] = 13'(c * 3);
        base = wr_ptr;
        build(13'h0055, 13'h00AA);
        start();
        for (int c = 0; c < 500 && rd_ptr < base + 65; c++) tick();
        stall = 1'b1;
        #1;
        check("t5_rd0", {31'd0, fifo_rd}, 32'd0);
        tick();
        n = got_q.size();
        for (int k = 0; k < 9; k++) begin
            check("t5_rd", {31'd0, fifo_rd}, 32'd0);
            check("t5_nov", {31'd0, out_valid}, 32'd0);
            tick();
        end
        check("t5_gap_words", got_q.size(), n);
        check("t5_ptr", rd_ptr, base + 65);
        check("t5_busy", {31'd0, busy}, 32'd1);
        stall = 1'b0;
        finish_frame("t5");
        check("t5_ch64", {10'd0, got_at(65)}, 32'h2400C0);
        check("t5_fcnt", {16'd0, frame_cnt}, 32'd5);

        // Reset mid-frame at ch40
        for (int c = 0; c < 128; c++) smp[c] = 13'(c);
        base = wr_ptr;
        build(13'h0999, 13'h0111);
        start();
        for (int c = 0; c < 500 && rd_ptr < base + 41; c++) tick();
        rst = 1'b1;
        flush = 1'b1;
        #1;
        check("t6_rst_fcnt", {16'd0, frame_cnt}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_rd", {31'd0, fifo_rd}, 32'd0);
        tick();
        rst = 1'b0;
        flush = 1'b0;
        for (int c = 0; c < 128; c++) ped_m[c] = 12'd0;
        tick();
        trl_cnt = 0;
        foreach (got_q[i]) if (got_q[i][21:20] == 2'b11) trl_cnt++;
        check("t6_no_trl", trl_cnt, 32'd0);
        for (int c = 0; c < 128; c++) smp[c] = 13'(c + 7);
        build(13'h0321, 13'h0654);
        start();
        finish_frame("t6");
        check("t6_hdr", {10'd0, got_at(0)}, 32'h100321);
        check("t6_ch5", {10'd0, got_at(6)}, 32'h20500C);
        check("t6_trl", {10'd0, got_at(129)}, 32'h380654);
        check("t6_fcnt", {16'd0, frame_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
